// File: rtl/piso.sv
// piso: parallel-in/serial-out shift register, loads on sl=0 and shifts out MSB first on sl=1.
module piso #(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             sl,
    output logic             q,
    input  logic             rst
);
    logic [WIDTH-1:0] shift_q, shift_d;
    always_comb shift_d = sl ? {shift_q[WIDTH-2:0], FILL} : d;
    always_ff @(posedge clk) shift_q <= rst ? '0 : shift_d;
    // q comes straight from the register so d and sl never reach the serial line combinationally
    assign q = shift_q[WIDTH-1];
endmodule

// File: tb/tb_piso.sv
// tb_piso: directed vectors drive piso while a monitor checks q after every edge against a queue of expected bits.
module tb_piso;
    logic [3:0] d;
    logic       clk = 1'b0;
    logic       sl;
    logic       q;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    int         step_n = 0;
    logic       exp_q[$];

    piso #(.WIDTH(4), .FILL(1'b0)) dut (.d(d), .clk(clk), .sl(sl), .q(q), .rst(rst));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic       sl;
        logic       rst;
        logic       exp;
    } vec_t;

    localparam int N = 26;
    vec_t vecs[N] = '{
        '{4'b1111, 1'b0, 1'b1, 1'b0}, '{4'b1111, 1'b0, 1'b1, 1'b0},
        '{4'b1111, 1'b0, 1'b0, 1'b1},
        '{4'b1011, 1'b0, 1'b0, 1'b1}, '{4'b0000, 1'b1, 1'b0, 1'b0},
        '{4'b0000, 1'b1, 1'b0, 1'b1}, '{4'b0000, 1'b1, 1'b0, 1'b1},
        '{4'b0000, 1'b1, 1'b0, 1'b0}, '{4'b0000, 1'b1, 1'b0, 1'b0},
        '{4'b0000, 1'b1, 1'b0, 1'b0},
        '{4'b1011, 1'b0, 1'b0, 1'b1}, '{4'b0000, 1'b1, 1'b0, 1'b0},
        '{4'b0100, 1'b0, 1'b0, 1'b0}, '{4'b0000, 1'b1, 1'b0, 1'b1},
        '{4'b0000, 1'b1, 1'b0, 1'b0},
        '{4'b1000, 1'b0, 1'b0, 1'b1}, '{4'b0000, 1'b0, 1'b0, 1'b0},
        '{4'b1001, 1'b0, 1'b0, 1'b1},
        '{4'b1111, 1'b0, 1'b1, 1'b0},
        '{4'b1011, 1'b0, 1'b0, 1'b1}, '{4'b0000, 1'b1, 1'b0, 1'b0},
        '{4'b1111, 1'b1, 1'b1, 1'b0}, '{4'b1111, 1'b1, 1'b0, 1'b0},
        '{4'b1111, 1'b1, 1'b0, 1'b0}, '{4'b1111, 1'b1, 1'b0, 1'b0},
        '{4'b0110, 1'b0, 1'b0, 1'b0}
    };

    initial begin
        d = '0;
        sl = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            d = vecs[i].d;
            sl = vecs[i].sl;
            rst = vecs[i].rst;
            exp_q.push_back(vecs[i].exp);
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL q step %0d got %b want %b", step_n, q, e);
            end
            step_n++;
        end
    end
endmodule
